// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus monitor: CTRL bit layout, HD44780
// instruction opcodes, DDRAM line map and the event/state enumerations.
package lcd_pkg;

    // CTRL = {DATA[7:0], E, XWRITE, RS}
    localparam int CTRL_RS       = 0;
    localparam int CTRL_RW       = 1;
    localparam int CTRL_E        = 2;
    localparam int CTRL_DATA_LSB = 3;
    localparam int CTRL_DATA_MSB = 10;

    // Instruction opcodes; the highest set bit selects the instruction
    localparam logic [7:0] OP_CLEAR    = 8'h01;
    localparam logic [7:0] OP_HOME     = 8'h02;
    localparam logic [7:0] OP_ENTRY    = 8'h04;
    localparam logic [7:0] OP_DISPLAY  = 8'h08;
    localparam logic [7:0] OP_SHIFT    = 8'h10;
    localparam logic [7:0] OP_FUNCTION = 8'h20;
    localparam logic [7:0] OP_CGRAM    = 8'h40;
    localparam logic [7:0] OP_DDRAM    = 8'h80;

    // Two-line DDRAM map
    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam logic [6:0] LINE0_LAST = 7'h27;
    localparam logic [6:0] LINE1_LAST = 7'h67;

    localparam int         SHADOW_AW   = 5;
    localparam logic [7:0] CLEAR_CHAR  = 8'h20;

    typedef enum logic [3:0] {
        EvtData     = 4'd0,
        EvtClear    = 4'd1,
        EvtHome     = 4'd2,
        EvtEntry    = 4'd3,
        EvtDisplay  = 4'd4,
        EvtShift    = 4'd5,
        EvtFunction = 4'd6,
        EvtCgram    = 4'd7,
        EvtDdram    = 4'd8
    } evt_code_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StExec  = 2'd1,
        StClear = 2'd2
    } mon_state_e;

    // Next address counter value, following the two-line wrap points
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if (ac == LINE0_LAST)      nxt = LINE1_BASE;
            else if (ac == LINE1_LAST) nxt = LINE0_BASE;
            else                       nxt = ac + 7'd1;
        end else begin
            if (ac == LINE0_BASE)      nxt = LINE1_LAST;
            else if (ac == LINE1_BASE) nxt = LINE0_LAST;
            else                       nxt = ac - 7'd1;
        end
        return nxt;
    endfunction

    // Instruction class from the highest set bit; zero is handled by the caller
    function automatic evt_code_e decode_instr(input logic [7:0] d);
        evt_code_e code;
        if ((d & OP_DDRAM) != 8'h00)         code = EvtDdram;
        else if ((d & OP_CGRAM) != 8'h00)    code = EvtCgram;
        else if ((d & OP_FUNCTION) != 8'h00) code = EvtFunction;
        else if ((d & OP_SHIFT) != 8'h00)    code = EvtShift;
        else if ((d & OP_DISPLAY) != 8'h00)  code = EvtDisplay;
        else if ((d & OP_ENTRY) != 8'h00)    code = EvtEntry;
        else if ((d & OP_HOME) != 8'h00)     code = EvtHome;
        else                                 code = EvtClear;
        return code;
    endfunction

endpackage

// File: rtl/lcd_ddram_shadow.sv
// 32x8 shadow of the visible DDRAM (2 lines x 16 columns).
// One write port, one synchronous read port; a same-cycle collision returns
// the old contents. The array itself is not reset.
module lcd_ddram_shadow
    import lcd_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [SHADOW_AW-1:0] wr_addr,
    input  logic [7:0]           wr_data,
    input  logic [SHADOW_AW-1:0] rd_addr,
    output logic [7:0]           rd_data
);

    logic [7:0] mem [2**SHADOW_AW];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read, read-before-write on collision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/lcd_bus_monitor.sv
// Passive HD44780-style LCD responder: decodes each E falling edge into an
// instruction or data access, keeps a 2x16 DDRAM shadow, address counter and
// display-on state, and flags protocol violations in sticky ERR bits.
// Optional E pulse width / RS-RW stability check: define LCDMON_PULSE_CHECK_EN.
module lcd_bus_monitor
    import lcd_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES       = 4000,
    parameter int unsigned CLEAR_BUSY_CYCLES = 153000,
    parameter int unsigned MIN_E_HIGH        = 45
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [10:0] CTRL,
    input  logic [4:0]  RD_ADDR,
    output logic [7:0]  RD_DATA,
    output logic [6:0]  AC,
    output logic        DISP_ON,
    output logic        BUSY,
    output logic        EVT,
    output logic [3:0]  EVT_CODE,
    output logic [2:0]  ERR
);

    localparam int CNT_W = $clog2(CLEAR_BUSY_CYCLES + 1);

    logic [10:0]    r_ctrl;
    logic [10:0]    ctrl_prev;
    logic           e_fall;
    logic           acc_rs;
    logic           acc_rw;
    logic [7:0]     acc_data;

    mon_state_e     state_q;
    logic           cmd_rs_q;
    logic [7:0]     cmd_data_q;
    evt_code_e      exec_code;
    logic [6:0]     ac_q;
    logic           id_q;
    logic           disp_q;
    logic           evt_q;
    evt_code_e      evt_code_q;
    logic           err_busy_q;
    logic           err_read_q;
    logic           err_timing;
    logic [4:0]     clr_idx_q;

    logic [CNT_W-1:0] busy_cnt_q;
    logic             busy_active;
    logic             busy_long;

    logic           wr_en;
    logic [4:0]     wr_addr;
    logic [7:0]     wr_data;

    // Bus sampling: r_ctrl is the registered bus, ctrl_prev the sample before
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ctrl    <= '0;
            ctrl_prev <= '0;
        end else begin
            r_ctrl    <= CTRL;
            ctrl_prev <= r_ctrl;
        end
    end

    // Access fields come from the last sample taken with E still high
    assign e_fall   = ctrl_prev[CTRL_E] & ~r_ctrl[CTRL_E];
    assign acc_rs   = ctrl_prev[CTRL_RS];
    assign acc_rw   = ctrl_prev[CTRL_RW];
    assign acc_data = ctrl_prev[CTRL_DATA_MSB:CTRL_DATA_LSB];

    assign exec_code   = cmd_rs_q ? EvtData : decode_instr(cmd_data_q);
    assign busy_active = (busy_cnt_q != '0);
    assign busy_long   = (exec_code == EvtClear) || (exec_code == EvtHome);

    // Busy window counter, reloaded by every executed access
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_cnt_q <= '0;
        end else if (state_q == StExec) begin
            busy_cnt_q <= busy_long ? CNT_W'(CLEAR_BUSY_CYCLES) : CNT_W'(BUSY_CYCLES);
        end else if (busy_active) begin
            busy_cnt_q <= busy_cnt_q - 1'b1;
        end
    end

    // Access decode/execute FSM with registered AC, display state, events and errors
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            cmd_rs_q   <= 1'b0;
            cmd_data_q <= 8'h00;
            ac_q       <= 7'h00;
            id_q       <= 1'b1;
            disp_q     <= 1'b0;
            evt_q      <= 1'b0;
            evt_code_q <= EvtData;
            err_busy_q <= 1'b0;
            err_read_q <= 1'b0;
            clr_idx_q  <= 5'd0;
        end else begin
            evt_q <= 1'b0;
            if (e_fall && (busy_active || state_q == StClear)) begin
                err_busy_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (e_fall) begin
                        if (acc_rw) begin
                            err_read_q <= 1'b1;
                        end else if (acc_rs || acc_data != 8'h00) begin
                            cmd_rs_q   <= acc_rs;
                            cmd_data_q <= acc_data;
                            state_q    <= StExec;
                        end
                    end
                end
                StExec: begin
                    evt_q      <= 1'b1;
                    evt_code_q <= exec_code;
                    state_q    <= StIdle;
                    unique case (exec_code)
                        EvtData:    ac_q   <= ac_step(ac_q, id_q);
                        EvtDdram:   ac_q   <= cmd_data_q[6:0];
                        EvtDisplay: disp_q <= cmd_data_q[2];
                        EvtEntry:   id_q   <= cmd_data_q[1];
                        EvtHome:    ac_q   <= 7'h00;
                        EvtClear: begin
                            id_q      <= 1'b1;
                            ac_q      <= 7'h00;
                            clr_idx_q <= 5'd0;
                            state_q   <= StClear;
                        end
                        default: ;
                    endcase
                end
                StClear: begin
                    // Accesses arriving here are dropped; only ERR_BUSY records them
                    clr_idx_q <= clr_idx_q + 5'd1;
                    if (clr_idx_q == 5'd31) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Shadow write port: clear fill has priority, else visible-column data writes
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = 5'd0;
        wr_data = 8'h00;
        if (state_q == StClear) begin
            wr_en   = 1'b1;
            wr_addr = clr_idx_q;
            wr_data = CLEAR_CHAR;
        end else if (state_q == StExec && cmd_rs_q && ac_q[5:4] == 2'b00) begin
            wr_en   = 1'b1;
            wr_addr = {ac_q[6], ac_q[3:0]};
            wr_data = cmd_data_q;
        end
    end

`ifdef LCDMON_PULSE_CHECK_EN
    localparam int HW = $clog2(MIN_E_HIGH + 2);

    logic [HW-1:0] e_high_cnt_q;
    logic [1:0]    rise_rsrw_q;
    logic          err_timing_q;

    // E-high width counter (saturating) and RS/RW captured at E rise
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            e_high_cnt_q <= '0;
            rise_rsrw_q  <= 2'b00;
        end else if (r_ctrl[CTRL_E] && !ctrl_prev[CTRL_E]) begin
            e_high_cnt_q <= HW'(1);
            rise_rsrw_q  <= {r_ctrl[CTRL_RW], r_ctrl[CTRL_RS]};
        end else if (r_ctrl[CTRL_E] && e_high_cnt_q != '1) begin
            e_high_cnt_q <= e_high_cnt_q + 1'b1;
        end
    end

    // Sticky timing error on a short pulse or RS/RW changing while E high
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_timing_q <= 1'b0;
        end else if (e_fall && ((e_high_cnt_q < HW'(MIN_E_HIGH)) ||
                                (rise_rsrw_q != {acc_rw, acc_rs}))) begin
            err_timing_q <= 1'b1;
        end
    end

    assign err_timing = err_timing_q;
`else
    assign err_timing = 1'b0;
`endif

    lcd_ddram_shadow u_shadow (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (RD_ADDR),
        .rd_data (RD_DATA)
    );

    assign AC       = ac_q;
    assign DISP_ON  = disp_q;
    assign BUSY     = busy_active || (state_q == StClear);
    assign EVT      = evt_q;
    assign EVT_CODE = evt_code_q;
    assign ERR      = {err_timing, err_read_q, err_busy_q};

endmodule

// File: doc/lcd_bus_monitor.md
Name: lcd_bus_monitor

Overview:
Passive responder on the HD44780-style 11-bit LCD control bus, i.e. the LCD end of the bus our LCD driver produces. Decodes each E-falling-edge access into instruction/data operations and keeps a 2x16 shadow of visible DDRAM, address counter and display state. Flags protocol violations: busy-time, unsupported read and, optionally, E pulse timing. Used for on-chip mirroring of the display (UART/debug readout) and as a self-checking monitor in the driver bench.

Parameters:
BUSY_CYCLES, 4000, busy window after a normal instruction/data write (40 us @ 100 MHz)
CLEAR_BUSY_CYCLES, 153000, busy window after Clear/Return Home (1.53 ms)
MIN_E_HIGH, 45, minimum E high width in CLK cycles (used only with LCDMON_PULSE_CHECK_EN)

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-high
CTRL  in  11  LCD bus {DATA[7:0], E, XWRITE(R/W), RS}; same clock domain as CLK
RD_ADDR  in  5  shadow read address {line, column[3:0]}
RD_DATA  out  8  shadow character at RD_ADDR
AC  out  7  current DDRAM address counter
DISP_ON  out  1  display-on bit from last Display Control instruction
BUSY  out  1  busy window or clear-fill active
EVT  out  1  one-cycle pulse per executed access
EVT_CODE  out  4  class of executed access: 0 data, 1 clear, 2 home, 3 entry, 4 display, 5 shift, 6 function, 7 CGRAM addr, 8 DDRAM addr
ERR  out  3  sticky {ERR_TIMING, ERR_READ, ERR_BUSY}

Behaviour:
- Reset (async, RST=1): shadow not cleared; AC=0, I/D=1, DISP_ON=0, BUSY=0, EVT=0, EVT_CODE=0, ERR=0, RD_DATA=0, state IDLE.
- CTRL registered once (r_ctrl). E fall = prev E=1 and r_ctrl E=0. RS/RW/DATA are taken from the sample with E still high, one cycle before the fall is detected.
- Access is executed, with EVT pulse and EVT_CODE, the cycle after the fall detect.
- RW=1: sets ERR_READ; no other effect; no EVT.
- RS=1, RW=0, data write:
  - If AC[3:0] is in 0..15 and AC[5:4]=0, write shadow[{AC[6],AC[3:0]}].
  - AC steps by +1 or -1 per I/D. Columns 0x10..0x27 are not stored but AC still advances.
- RS=0, RW=0: decode on the highest set bit.
  - 1xxxxxxx: AC=D[6:0].
  - 01xxxxxx: CGRAM address; ignored, EVT only.
  - 001xxxxx: function set; ignored, EVT only.
  - 0001xxxx: cursor/display shift; ignored, EVT only.
  - 00001DCB: DISP_ON=D.
  - 000001IS: I/D=I; S ignored.
  - 0000001x: AC=0.
  - 00000001: I/D=1, AC=0, enter CLEAR.
  - 0x00: no-op, no EVT.
- AC wrap (2-line map):
  - Increment: 0x27->0x40, 0x67->0x00.
  - Decrement: 0x00->0x67, 0x40->0x27.
  - AC values outside both ranges, set via DDRAM addr, are taken as is; next step uses plain +/-1 with the same wrap points.
- Busy:
  - Each executed write/instruction loads the busy counter: CLEAR_BUSY_CYCLES for clear/home, else BUSY_CYCLES. BUSY=1 while counter != 0.
  - An E fall while the counter != 0 sets ERR_BUSY; the access still executes and reloads the counter.
- States:
  - IDLE -> EXEC on E fall.
  - EXEC -> CLEAR for a clear instruction; EXEC -> IDLE otherwise.
  - CLEAR writes 0x20 to shadow[0..31], one per cycle (32 cycles), then -> IDLE.
  - E fall during CLEAR: ERR_BUSY set, access dropped (no EVT).
- Read port: synchronous, RD_DATA valid 1 cycle after RD_ADDR. A write to the same address in the same cycle returns old data.
- ERR bits are cleared only by reset.

Optional Feature:
LCDMON_PULSE_CHECK_EN
- With: count E-high cycles and record RS/RW at E rise. Set ERR_TIMING if E high < MIN_E_HIGH, or if RS/RW differ at fall vs rise; the access still executes.
- Without: ERR_TIMING tied 0; no counter logic.

Decomposition:
- Package lcd_pkg:
  - CTRL bit positions.
  - Instruction opcodes/masks (CLEAR 0x01, HOME 0x02, ENTRY 0x04, DISPLAY 0x08, SHIFT 0x10, FUNCTION 0x20, CGRAM 0x40, DDRAM 0x80).
  - Line base addresses 0x00/0x40 and wrap limits 0x27/0x67.
  - EVT_CODE enum and monitor state enum.
- Sub-module lcd_ddram_shadow: 32x8 RAM, one write port, one synchronous read port.

Test Plan:
- Send 0x3C, 0x3C, 0x0C, 0x01, 0x06 with legal timing -> EVT_CODE 6, 6, 4, 1, 3; DISP_ON=1; shadow all 0x20; ERR=0.
- Send 0x80, then data 0x42 'B' -> shadow[0]=0x42, AC=0x01.
- Send 0xC4, then data 0x31, 0x32, 0x33 -> shadow[20..22]=31/32/33, AC=0x47.
- Send 0xA7 (AC=0x27), data 0x41 -> nothing stored, AC=0x40. Entry 0x04 (I/D=0), AC=0x40, data -> shadow[16] written, AC=0x27.
- Clear, then second E fall 10 cycles later -> second access dropped, ERR_BUSY=1. Access 100 cycles after a data write -> ERR_BUSY=1 and the access executes.
- Access with RW=1 -> ERR_READ=1, no EVT. With LCDMON_PULSE_CHECK_EN, E high 10 cycles -> ERR_TIMING=1 and the write still stored.
